// File: rtl/difftest_vec_pkg.sv
// difftest_vec_pkg: shared types and widths for vector-register writeback events
package difftest_vec_pkg;
  localparam int VEC_ADDR_W = 7;
  localparam int VEC_DATA_W = 64;
  typedef struct packed {
    logic [VEC_ADDR_W-1:0] address;
    logic [VEC_DATA_W-1:0] data_1;
    logic [VEC_DATA_W-1:0] data_0;
  } vec_wb_entry_t;
endpackage

// File: rtl/vec_wb_fifo.sv
// vec_wb_fifo: per-port writeback FIFO with wrap-bit pointers
module vec_wb_fifo
  import difftest_vec_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  vec_wb_entry_t din,
  output logic          full,
  output logic          empty,
  output vec_wb_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  vec_wb_entry_t mem [DEPTH];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  // fullness is judged on pre-edge state, so a push into a full FIFO drops even when it pops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/difftest_vec_wb_arbiter.sv
// difftest_vec_wb_arbiter: round-robin serialiser of per-port vector writebacks onto one probe
module difftest_vec_wb_arbiter
  import difftest_vec_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 8,
  parameter int DROP_W    = 16
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  io_in_valid,
  input  logic [NUM_PORTS-1:0][VEC_ADDR_W-1:0]  io_in_address,
  input  logic [NUM_PORTS-1:0][VEC_DATA_W-1:0]  io_in_data_0,
  input  logic [NUM_PORTS-1:0][VEC_DATA_W-1:0]  io_in_data_1,
  output logic [NUM_PORTS-1:0]                  io_in_ready,
  input  logic [7:0]                            io_coreid,
  output logic                                  out_enable,
  output logic [VEC_ADDR_W-1:0]                 out_address,
  output logic [VEC_DATA_W-1:0]                 out_data_0,
  output logic [VEC_DATA_W-1:0]                 out_data_1,
  output logic [7:0]                            out_coreid,
  output logic                                  overflow,
  output logic [DROP_W-1:0]                     drop_count
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(NUM_PORTS + 1);
  logic [NUM_PORTS-1:0] full, empty, pop, drop;
  vec_wb_entry_t head [NUM_PORTS];
  logic [PW-1:0] rr, gnt, idx;
  logic gnt_valid;
  logic [CW-1:0] n_drop;
  logic [DROP_W:0] drop_sum;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    vec_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (io_in_valid[i]),
      .pop    (pop[i]),
      .din    ({io_in_address[i], io_in_data_1[i], io_in_data_0[i]}),
      .full   (full[i]),
      .empty  (empty[i]),
      .head   (head[i])
    );
    assign pop[i] = gnt_valid && gnt == PW'(i);
  end
  assign io_in_ready = ~full;
  assign drop        = io_in_valid & full;
  assign out_coreid  = io_coreid;
  // scan downward so the first non-empty port at or after rr wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(rr) + k) % NUM_PORTS);
      if (!empty[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end
  always_comb begin
    n_drop = '0;
    for (int k = 0; k < NUM_PORTS; k++) n_drop += CW'(drop[k]);
  end
  assign drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(n_drop);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr          <= '0;
      out_enable  <= 1'b0;
      out_address <= '0;
      out_data_0  <= '0;
      out_data_1  <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      out_enable <= gnt_valid;
      if (gnt_valid) begin
        rr <= (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
        {out_address, out_data_1, out_data_0} <= head[gnt];
      end
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_difftest_vec_wb_arbiter.sv
// tb_difftest_vec_wb_arbiter: directed checks of push, arbitration, drops, saturation and async reset
module tb_difftest_vec_wb_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] io_in_valid;
  logic [3:0][6:0] io_in_address;
  logic [3:0][63:0] io_in_data_0, io_in_data_1;
  logic [3:0] io_in_ready;
  logic [7:0] io_coreid;
  logic out_enable;
  logic [6:0] out_address;
  logic [63:0] out_data_0, out_data_1;
  logic [7:0] out_coreid;
  logic overflow;
  logic [3:0] drop_count;
  int tests = 0;
  int fails = 0;
  logic mon_on = 1'b0;
  int mon_total = 0;
  int p1_seq[$];

  always #5 clock = ~clock;

  difftest_vec_wb_arbiter #(.NUM_PORTS(4), .DEPTH(8), .DROP_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_in_valid  (io_in_valid),
    .io_in_address(io_in_address),
    .io_in_data_0 (io_in_data_0),
    .io_in_data_1 (io_in_data_1),
    .io_in_ready  (io_in_ready),
    .io_coreid    (io_coreid),
    .out_enable   (out_enable),
    .out_address  (out_address),
    .out_data_0   (out_data_0),
    .out_data_1   (out_data_1),
    .out_coreid   (out_coreid),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always @(negedge clock) begin
    if (mon_on && out_enable) begin
      mon_total++;
      if (out_address[6:4] == 3'd1) p1_seq.push_back(int'(out_address[3:0]));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input int n);
    io_in_valid[p]   = 1'b1;
    io_in_address[p] = 7'(p * 16 + n);
    io_in_data_0[p]  = (64'(p) << 32) | 64'(n);
    io_in_data_1[p]  = ~((64'(p) << 32) | 64'(n));
  endtask

  task automatic do_reset();
    io_in_valid = '0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    io_coreid     = 8'hA5;
    io_in_valid   = '0;
    io_in_address = '0;
    io_in_data_0  = '0;
    io_in_data_1  = '0;
    do_reset();
    check("rst_enable", out_enable, 0);
    check("rst_address", out_address, 0);
    check("rst_data0", out_data_0, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
    check("rst_ready", io_in_ready, 4'hf);

    io_in_valid[2]   = 1'b1;
    io_in_address[2] = 7'd5;
    io_in_data_0[2]  = 64'h1111;
    io_in_data_1[2]  = 64'h2222;
    tick();
    io_in_valid = '0;
    check("single_no_early", out_enable, 0);
    tick();
    check("single_enable", out_enable, 1);
    check("single_address", out_address, 5);
    check("single_data0", out_data_0, 64'h1111);
    check("single_data1", out_data_1, 64'h2222);
    check("coreid_a5", out_coreid, 8'hA5);
    tick();
    check("single_one_pulse", out_enable, 0);
    check("single_hold", out_address, 5);
    io_coreid = 8'h3C;
    #1;
    check("coreid_3c", out_coreid, 8'h3C);

    do_reset();
    for (int p = 0; p < 4; p++) drive(p, 0);
    tick();
    io_in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("burst_enable", out_enable, 1);
      check("burst_order", out_address, 64'(k * 16));
    end
    tick();
    check("burst_end", out_enable, 0);
    drive(3, 1);
    drive(0, 1);
    tick();
    io_in_valid = '0;
    tick();
    check("rr_wrap_first", out_address, 1);
    tick();
    check("rr_wrap_second", out_address, 49);

    do_reset();
    mon_total = 0;
    mon_on = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      io_in_valid = '0;
      if (e <= 5) begin
        drive(0, e - 1);
        drive(2, e - 1);
        drive(3, e - 1);
      end
      drive(1, e - 1);
      tick();
      if (e == 9) check("p1_ready_before_full", io_in_ready, 4'hf);
      if (e == 10) begin
        check("p1_ready_full", io_in_ready, 4'b1101);
        check("p1_no_drop_yet", drop_count, 0);
        check("p1_no_overflow_yet", overflow, 0);
      end
      if (e == 11) begin
        check("p1_overflow", overflow, 1);
        check("p1_drop_on_pop", drop_count, 1);
        check("p1_ready_after_pop", io_in_ready, 4'hf);
      end
    end
    io_in_valid = '0;
    repeat (20) tick();
    mon_on = 1'b0;
    check("drain_total", 64'(mon_total), 25);
    check("p1_accepted", 64'(p1_seq.size()), 10);
    for (int k = 0; k < p1_seq.size(); k++) check("p1_order", 64'(p1_seq[k]), 64'(k));

    do_reset();
    for (int e = 1; e <= 17; e++) begin
      for (int p = 0; p < 4; p++) drive(p, (e - 1) & 15);
      tick();
      if (e == 10) begin
        check("sat_ready", io_in_ready, 4'b0001);
        check("sat_drops_0", drop_count, 0);
      end
      if (e == 11) check("sat_drops_3", drop_count, 3);
      if (e == 14) check("sat_drops_12", drop_count, 12);
      if (e == 15) check("sat_drops_15", drop_count, 15);
      if (e == 16) check("sat_hold_16", drop_count, 15);
      if (e == 17) check("sat_hold_17", drop_count, 15);
    end
    io_in_valid = '0;
    check("midburst_active", out_enable, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_enable", out_enable, 0);
    check("async_address", out_address, 0);
    check("async_data0", out_data_0, 0);
    check("async_data1", out_data_1, 0);
    check("async_overflow", overflow, 0);
    check("async_drops", drop_count, 0);
    check("async_ready", io_in_ready, 4'hf);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_reset_idle", out_enable, 0);
    end
    drive(1, 3);
    tick();
    io_in_valid = '0;
    tick();
    check("post_reset_enable", out_enable, 1);
    check("post_reset_address", out_address, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
